mem_arbiter: RTL
================

# mem_arbiter

Shares the single-ported unified memory between the instruction-fetch stage and the load/store path of the MIPS core. Each requester uses a level request/acknowledge handshake. The arbiter registers the winning request onto the memory port and waits for a variable-latency memory acknowledge. It then returns read data plus a one-cycle acknowledge to the winner. Data accesses have priority, and a streak limit guarantees fetch progress; a watchdog terminates accesses the memory never answers.

## Interface
- AW, 32, address width
- DW, 32, data width
- DATA_STREAK, 4, max consecutive data grants while a fetch is pending (>=1)
- TIMEOUT, 255, cycles to wait for mem_ack before error-completing; 0 disables the watchdog
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, level
- i_addr  in  AW  fetch address, stable while i_req high
- i_ack  out  1  one-cycle fetch completion
- i_rdata  out  DW  fetch data, valid with i_ack
- i_err  out  1  fetch timed out, valid with i_ack
- d_req  in  1  load/store request, level
- d_we  in  1  1 = store
- d_be  in  DW/8  store byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle data completion
- d_rdata  out  DW  load data, valid with d_ack
- d_err  out  1  data timed out, valid with d_ack
- mem_ce  out  1  memory access active
- mem_we  out  1  write strobe
- mem_be  out  DW/8  byte enables (all ones on reads)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, sampled with mem_ack
- mem_ack  in  1  memory completion; only meaningful while mem_ce high

## Operation
- FSM states: IDLE, IBUSY, DBUSY.
- IDLE: eligible requesters are those with req high and ack not asserted this cycle.
  - Only d eligible: grant d. Only i eligible: grant i.
  - Both eligible: grant d, unless streak == DATA_STREAK; then grant i.
  - On grant, latch addr/we/be/wdata into mem_* registers, set mem_ce, go to IBUSY/DBUSY.
  - Fetch grants force mem_we=0 and mem_be=all ones. Data reads also force mem_be=all ones.
- BUSY: hold mem_* constant.
  - On mem_ack: drop mem_ce and mem_we, register mem_rdata into the winner's rdata, pulse the winner's ack next cycle with err=0, return to IDLE.
- Watchdog: counter cleared at grant, increments each BUSY cycle without mem_ack.
  - On reaching TIMEOUT: complete as above with err=1 and rdata=0.
  - mem_ack in the same cycle the count reaches TIMEOUT counts as normal completion (err=0).
- Streak counter:
  - +1 on a d grant while i_req is high; saturates at DATA_STREAK.
  - Cleared on any i grant, and on a d grant while i_req is low.
- i_rdata and d_rdata hold their last value between acks.
- A req still high in the ack cycle is ignored; if it is still high the following cycle, it is a new request.
- Reset, including mid-access: FSM=IDLE, all counters 0, and mem_ce, mem_we, i_ack, d_ack, i_err, d_err all 0. mem_be, mem_addr, mem_wdata, i_rdata and d_rdata are also 0. No completion is issued for the aborted access.

## Timing
- Grant latency: req high in IDLE at cycle 0 -> mem_ce high from cycle 1.
- Completion latency: mem_ack at cycle k -> ack/rdata/err at cycle k+1. State is IDLE at k+1, and a new grant becomes visible at k+2.
- Zero-wait memory (mem_ack in the first mem_ce cycle): 2 cycles from req to ack, 3-cycle back-to-back throughput.
- Timeout: if no mem_ack, the ack (err=1) arrives at cycle 1+TIMEOUT+1 relative to the grant cycle 0.
- mem_ack while in IDLE is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared define file additions:
  - FSM state encodings `ARB_IDLE`/`ARB_IBUSY`/`ARB_DBUSY`
  - requester IDs `ARB_I`/`ARB_D`
- Sub-module `arb_watchdog`: clear/enable/expired counter parameterised by TIMEOUT (disabled when 0).
- Streak logic stays inline.

## Test plan
- i_req only, addr 0x0000_0040, mem_ack on first ce cycle with rdata 0x2402_0005:
  - mem_ce cycle 1, i_ack cycle 2, i_rdata=0x2402_0005, i_err=0.
- d_req store, addr 0x100, be 4'b0011, wdata 0xDEAD_BEEF:
  - mem_we=1, mem_be=4'b0011, mem_wdata=0xDEAD_BEEF held through a 3-cycle-late mem_ack.
  - d_ack one cycle after mem_ack.
- i_req and d_req both held continuously, zero-wait memory, DATA_STREAK=4:
  - grant order d,d,d,d,i,d,d,d,d,i.
  - No requester starves.
- TIMEOUT=8, d read, mem_ack never asserted:
  - d_ack with d_err=1 and d_rdata=0 exactly 10 cycles after the grant cycle.
  - mem_ce low afterwards.
- rst asserted mid-IBUSY:
  - mem_ce, i_ack and state cleared asynchronously.
  - After release, a fresh i_req is granted normally.
- Requester keeps req high through its ack cycle:
  - No grant in the ack cycle.
  - Re-granted the next cycle as a new access.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch / load-store memory arbiter: FSM states,
// requester identifiers and a counter-width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IBUSY = 2'd1,
    ARB_DBUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_id_e;

  // Bits needed to hold the values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter for the arbiter: cleared on grant, counts enabled cycles,
// flags expiry at TIMEOUT. TIMEOUT = 0 disables it.
module arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int            CW    = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data has priority; a streak limit forces a fetch grant after DATA_STREAK data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DATA_STREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  output logic            mem_ce,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack
);

  localparam int            BW         = DW / 8;
  localparam int            SW         = cnt_width(DATA_STREAK);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK);

  arb_state_e r_state, w_state_nxt;
  arb_id_e    w_grant_id;
  logic       w_grant, w_done, w_err, w_expired;
  logic       w_i_elig, w_d_elig;

  logic          r_mem_ce, r_mem_we;
  logic [BW-1:0] r_mem_be;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_i_ack, r_d_ack, r_i_err, r_d_err;
  logic [DW-1:0] r_i_rdata, r_d_rdata;
  logic [SW-1:0] r_streak;

  // The completion cycle is a dead cycle for arbitration: a level request that
  // is still high while an ack is out is only treated as new one cycle later.
  assign w_i_elig = i_req && !r_i_ack && !r_d_ack;
  assign w_d_elig = d_req && !r_i_ack && !r_d_ack;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_grant),
    .i_en     ((r_state != ARB_IDLE) && !mem_ack),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_id  = ARB_D;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_d_elig && !(w_i_elig && (r_streak == STREAK_MAX))) begin
          w_grant     = 1'b1;
          w_grant_id  = ARB_D;
          w_state_nxt = ARB_DBUSY;
        end else if (w_i_elig) begin
          w_grant     = 1'b1;
          w_grant_id  = ARB_I;
          w_state_nxt = ARB_IBUSY;
        end
      end
      ARB_IBUSY, ARB_DBUSY: begin
        // A memory ack in the expiry cycle wins over the timeout.
        if (mem_ack || w_expired) begin
          w_done      = 1'b1;
          w_err       = !mem_ack;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so the memory port and read
  // data buses come out of reset at zero rather than holding stale values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_err     <= 1'b0;
      r_d_err     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_i_err <= 1'b0;
      r_d_err <= 1'b0;
      if (w_grant) begin
        r_mem_ce <= 1'b1;
        if (w_grant_id == ARB_D) begin
          r_mem_addr  <= d_addr;
          r_mem_we    <= d_we;
          r_mem_be    <= d_we ? d_be : '1;
          r_mem_wdata <= d_wdata;
        end else begin
          r_mem_addr <= i_addr;
          r_mem_we   <= 1'b0;
          r_mem_be   <= '1;
        end
      end else if (w_done) begin
        r_mem_ce <= 1'b0;
        r_mem_we <= 1'b0;
        if (r_state == ARB_IBUSY) begin
          r_i_ack   <= 1'b1;
          r_i_err   <= w_err;
          r_i_rdata <= w_err ? '0 : mem_rdata;
        end else begin
          r_d_ack   <= 1'b1;
          r_d_err   <= w_err;
          r_d_rdata <= w_err ? '0 : mem_rdata;
        end
      end
    end
  end

  // Streak counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (w_grant) begin
      if (w_grant_id == ARB_I || !i_req) r_streak <= '0;
      else if (r_streak != STREAK_MAX)   r_streak <= r_streak + 1'b1;
    end
  end

  assign mem_ce    = r_mem_ce;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_ack     = r_i_ack;
  assign i_err     = r_i_err;
  assign i_rdata   = r_i_rdata;
  assign d_ack     = r_d_ack;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;

endmodule
